// File: rtl/uart_cmd_pkg.sv
// Shared header codes and decoder states for the UART command decoder.
// Both the decoder and the bench's interface refer to these.
package uart_cmd_pkg;

    localparam int BYTE_W  = 8;
    localparam int MAX_SIG = 6;

    typedef enum logic [1:0] {
        HDR_CLEAR = 2'b00,
        HDR_LEVEL = 2'b01,
        HDR_PULSE = 2'b10,
        HDR_EXT   = 2'b11
    } hdr_e;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_EXT = 1'b1
    } state_e;

endpackage

// File: rtl/uart_cmd_decoder_if.sv
// Received-byte strobe and data coming from the UART receiver into the decoder.
interface uart_cmd_decoder_if;
    import uart_cmd_pkg::*;

    logic              data_valid;
    logic [BYTE_W-1:0] data_receive;

    modport master (
        output data_valid,
        output data_receive
    );

    modport slave (
        input data_valid,
        input data_receive
    );

endinterface

// File: rtl/uart_cmd_decoder_cycle_timer.sv
// Free-running up-counter that restarts on request and sticks at its last count,
// flagging expiry for as long as it is parked there.
module cycle_timer #(
    parameter int PERIOD = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic expired
);

    localparam int          W    = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [W-1:0] LAST = W'(PERIOD - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            count <= '0;
        end else if (count != LAST) begin
            count <= count + W'(1);
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/uart_cmd_decoder.sv
// Decodes received UART bytes into level, pulse and masked-update commands,
// with a link watchdog and a timeout on the second byte of extended frames.
module uart_cmd_decoder
    import uart_cmd_pkg::*;
#(
    parameter int NUM_SIG         = 4,
    parameter int TIMEOUT_CYCLES  = 100_000_000,
    parameter int EXT_WAIT_CYCLES = 1_000_000
) (
    input  logic               clk,
    input  logic               rst,
    uart_cmd_decoder_if.slave  rx,
    output logic [NUM_SIG-1:0] sig_out,
    output logic [NUM_SIG-1:0] pulse_out,
    output logic [NUM_SIG-1:0] feedback_leds,
    output logic               led_mode,
    output logic               link_alive,
    output logic               frame_err
);

    state_e             state;
    logic [NUM_SIG-1:0] ext_value;
    logic [NUM_SIG-1:0] payload;
    hdr_e               header;
    logic               frame_accept;
    logic               wdog_expired;
    logic               ext_expired;
    logic               ext_restart;
    logic               unused_byte_bits;

    assign payload = rx.data_receive[NUM_SIG+1:2];
    assign header  = hdr_e'(rx.data_receive[1:0]);

    // Byte bits above the payload carry nothing when NUM_SIG < 6.
    assign unused_byte_bits = &{1'b0, rx.data_receive};

    assign frame_accept = rx.data_valid && ((state == WAIT_EXT) || (header != HDR_EXT));
    assign ext_restart  = (state != WAIT_EXT);

    cycle_timer #(
        .PERIOD (TIMEOUT_CYCLES)
    ) u_wdog_timer (
        .clk     (clk),
        .rst     (rst),
        .restart (frame_accept),
        .expired (wdog_expired)
    );

    cycle_timer #(
        .PERIOD (EXT_WAIT_CYCLES)
    ) u_ext_timer (
        .clk     (clk),
        .rst     (rst),
        .restart (ext_restart),
        .expired (ext_expired)
    );

    // A received byte always takes priority over either timer expiring that cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            ext_value     <= '0;
            sig_out       <= '0;
            pulse_out     <= '0;
            feedback_leds <= '0;
            led_mode      <= 1'b0;
            link_alive    <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            pulse_out <= '0;
            frame_err <= 1'b0;

            if (frame_accept) begin
                link_alive <= 1'b1;
            end

            if (rx.data_valid) begin
                case (state)
                    IDLE: begin
                        case (header)
                            HDR_CLEAR: begin
                                sig_out       <= '0;
                                feedback_leds <= '0;
                                led_mode      <= 1'b0;
                            end
                            HDR_LEVEL: begin
                                sig_out       <= payload;
                                feedback_leds <= payload;
                                led_mode      <= 1'b1;
                            end
                            HDR_PULSE: begin
                                pulse_out     <= payload;
                                feedback_leds <= payload;
                                led_mode      <= 1'b1;
                            end
                            HDR_EXT: begin
                                ext_value <= payload;
                                state     <= WAIT_EXT;
                            end
                            default: begin
                                state <= IDLE;
                            end
                        endcase
                    end
                    WAIT_EXT: begin
                        sig_out       <= (sig_out & ~payload) | (ext_value & payload);
                        feedback_leds <= ext_value;
                        led_mode      <= 1'b1;
                        state         <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end else begin
                if (wdog_expired) begin
                    sig_out       <= '0;
                    feedback_leds <= '0;
                    led_mode      <= 1'b0;
                    link_alive    <= 1'b0;
                end
                if ((state == WAIT_EXT) && ext_expired) begin
                    frame_err <= 1'b1;
                    state     <= IDLE;
                end
            end
        end
    end

endmodule

// File: doc/uart_cmd_decoder.md
UART_CMD_DECODER -- requirements
Module: uart_cmd_decoder

Interface
REQ-001 The block SHALL have parameter NUM_SIG, default 4, meaning the number of control signals; legal range 1..6.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 100_000_000, meaning the link watchdog period in clk cycles.
REQ-003 The block SHALL have parameter EXT_WAIT_CYCLES, default 1_000_000, meaning the maximum gap between the two bytes of an extended frame.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port data_valid, input, 1 bit: one-cycle strobe in the clk domain marking a received byte.
REQ-007 The block SHALL have port data_receive, input, 8 bits: the received byte; [1:0] is the header and [NUM_SIG+1:2] is the payload.
REQ-008 The block SHALL have port sig_out, output, NUM_SIG bits: registered level control signals.
REQ-009 The block SHALL have port pulse_out, output, NUM_SIG bits: one-cycle command pulses.
REQ-010 The block SHALL have port feedback_leds, output, NUM_SIG bits: the last accepted payload.
REQ-011 The block SHALL have port led_mode, output, 1 bit: high while a non-clear command is in effect.
REQ-012 The block SHALL have port link_alive, output, 1 bit: high while the watchdog has not expired.
REQ-013 The block SHALL have port frame_err, output, 1 bit: one-cycle pulse when an extended frame is abandoned.

Function
REQ-014 Bytes SHALL be sampled only on cycles with data_valid=1; all outputs SHALL update on the clk edge following the sampling edge (latency 1 cycle).
REQ-015 Payload bits above NUM_SIG+1 SHALL be ignored; with NUM_SIG=6, every byte bit SHALL be used.
REQ-016 Header 00 (clear) SHALL zero sig_out and feedback_leds and clear led_mode.
REQ-017 Header 01 (level) SHALL load the payload into sig_out and feedback_leds and set led_mode.
REQ-018 Header 10 (pulse) SHALL drive the payload on pulse_out for exactly one cycle, load feedback_leds, set led_mode, and leave sig_out unchanged.
REQ-019 Header 11 (extended) SHALL latch the payload as value V and move the FSM from IDLE to WAIT_EXT with no output change.
REQ-020 In WAIT_EXT, the next valid byte SHALL be taken whole as mask M, regardless of its bits [1:0].
REQ-021 On receipt of mask M, sig_out SHALL become (sig_out AND NOT M) OR (V AND M), feedback_leds SHALL load V, led_mode SHALL be set, and the FSM SHALL return to IDLE.
REQ-022 If no byte arrives within EXT_WAIT_CYCLES cycles of entering WAIT_EXT, frame_err SHALL pulse for one cycle and the FSM SHALL return to IDLE, with outputs unchanged and the watchdog not restarted.
REQ-023 Every accepted frame (headers 00, 01 or 10, or a completed extended frame) SHALL restart the watchdog counter and set link_alive.
REQ-024 When the watchdog counter reaches TIMEOUT_CYCLES-1, the block SHALL clear sig_out, feedback_leds and led_mode, and drop link_alive.
REQ-025 The watchdog counter SHALL then hold until the next accepted frame, with no wrap-around.
REQ-026 When data_valid coincides with watchdog or EXT timer expiry, the byte SHALL win: it is processed normally and the expiry action is suppressed.
REQ-027 pulse_out SHALL be zero on every cycle except the one following a pulse command.

Reset
REQ-028 While rst=1 at a clk edge, the block SHALL set the FSM to IDLE, clear both counters, and drive sig_out, pulse_out, feedback_leds, led_mode, link_alive and frame_err to 0.
REQ-029 rst asserted while the FSM is in WAIT_EXT SHALL discard the pending V.
REQ-030 The first frame after reset SHALL be decoded normally.

Structure
REQ-031 The header codes (HDR_CLEAR, HDR_LEVEL, HDR_PULSE, HDR_EXT) and the FSM state encoding (IDLE, WAIT_EXT) SHALL live in the shared package uart_cmd_pkg.
REQ-032 Both timeouts SHALL use two instances of one sub-module, cycle_timer, parametrised by period, with ports clk, rst, restart, expired and sticky hold at expiry.

Verification
REQ-033 Bench: NUM_SIG=4, byte 0x15 (level, payload 0101) -> next cycle sig_out=0101, feedback_leds=0101, led_mode=1, link_alive=1.
REQ-034 Bench: byte 0x0E (pulse, payload 0011) -> pulse_out=0011 for exactly 1 cycle, then 0000; sig_out unchanged.
REQ-035 Bench: sig_out=0101, then bytes 0x2B (V=1010) and 0x0C (M=0011) -> sig_out=0110 after the second byte; no change after the first byte.
REQ-036 Bench: byte 0x2B, then no byte for EXT_WAIT_CYCLES (bench value 16) -> frame_err pulses once, sig_out unchanged, and the next 0x15 is decoded as level.
REQ-037 Bench: TIMEOUT_CYCLES=32, level 0x3D, then idle -> sig_out=0000, led_mode=0, link_alive=0 after 32 cycles; a byte arriving on the expiry cycle instead keeps link_alive=1.
REQ-038 Bench: rst pulsed after byte 0x2B -> all outputs 0, and a following 0x0C is decoded as a header-00 clear, not as a mask.
